// File: rtl/gb_framebuffer.sv
// gb_framebuffer: Game Boy frame store with ping-pong line prefetch for scan-out.
//
// Ports
//   clock25            sole clock
//   resetn             synchronous active-low reset
//   pix_valid/pix_sof  PPU pixel strobe; sof marks frame position (0,0)
//   pix_shade[1:0]     2-bit shade of the presented pixel
//   lcd_en             LCD enable; low forces the lightest palette colour
//   x[11:0], y[11:0]   scan-out coordinates
//   r/g/b[7:0]         combinational pixel colour for (x, y)
//   ready              initial two-line prefetch has completed
//
// Fetch FSM
//   state   | meaning
//   S_INIT0 | after reset: fetch line 0 into the front buffer
//   S_INIT1 | fetch line 1 into the back buffer, then raise ready
//   S_IDLE  | wait for the scan-out line to change
//   S_FETCH | seek base to fetch_line, then read WIDTH pixels into back
module gb_framebuffer #(
  parameter int          WIDTH  = 160,
  parameter int          HEIGHT = 144,
  parameter logic [23:0] PAL0   = 24'hE0F8D0,
  parameter logic [23:0] PAL1   = 24'h88C070,
  parameter logic [23:0] PAL2   = 24'h346856,
  parameter logic [23:0] PAL3   = 24'h081820
) (
  input  logic        clock25,
  input  logic        resetn,
  input  logic        pix_valid,
  input  logic        pix_sof,
  input  logic [1:0]  pix_shade,
  input  logic        lcd_en,
  input  logic [11:0] x,
  input  logic [11:0] y,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        ready
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);
  localparam int IW    = $clog2(WIDTH + 1);
  localparam int XW    = $clog2(WIDTH);
  localparam int LW    = $clog2(HEIGHT);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] STRIDE    = AW'(WIDTH);
  localparam logic [IW-1:0] IDX_END   = IW'(WIDTH);

  typedef enum logic [1:0] {S_INIT0, S_INIT1, S_IDLE, S_FETCH} state_t;

  logic [1:0]    frame_mem [DEPTH];
  logic [1:0]    ram_rdata;
  logic [AW-1:0] rd_addr;
  logic          rd_en;
  logic [AW-1:0] mem_waddr;

  logic [AW-1:0] wr_addr_q, wr_addr_d;
  state_t        state_q, state_d;
  logic          ready_q, ready_d;
  logic [11:0]   y_prev_q, y_prev_d;
  logic          front_sel_q, front_sel_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] base_q, base_d;
  logic [LW-1:0] base_line_q, base_line_d;
  logic [LW-1:0] fetch_line_q, fetch_line_d;
  logic          wr_pend_q, wr_pend_d;
  logic [IW-1:0] wr_idx_q, wr_idx_d;
  logic          wr_buf_q, wr_buf_d;
  logic [1:0]    lb0_q [WIDTH];
  logic [1:0]    lb0_d [WIDTH];
  logic [1:0]    lb1_q [WIDTH];
  logic [1:0]    lb1_d [WIDTH];

  logic          line_change;
  logic [LW-1:0] next_line;
  logic [XW-1:0] x_idx;
  logic [1:0]    shade;
  logic [23:0]   rgb;

  // Write side: sof restarts the raster count at 0 no matter where it was.
  always_comb begin
    mem_waddr = wr_addr_q;
    wr_addr_d = wr_addr_q;
    if (pix_valid) begin
      if (pix_sof) begin
        mem_waddr = '0;
        wr_addr_d = AW'(1);
      end else begin
        wr_addr_d = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + AW'(1);
      end
    end
  end

  // Dual-port RAM, read-before-write on address collision; never reset.
  always_ff @(posedge clock25) begin
    if (pix_valid) frame_mem[mem_waddr] <= pix_shade;
    if (rd_en)     ram_rdata <= frame_mem[rd_addr];
  end

  assign line_change = ready_q && (y != y_prev_q);
  assign next_line   = (y >= 12'(HEIGHT - 1)) ? '0 : y[LW-1:0] + LW'(1);

  always_comb begin
    state_d      = state_q;
    ready_d      = ready_q;
    y_prev_d     = y;
    front_sel_d  = front_sel_q;
    idx_d        = idx_q;
    base_d       = base_q;
    base_line_d  = base_line_q;
    fetch_line_d = fetch_line_q;
    wr_pend_d    = 1'b0;
    wr_idx_d     = idx_q;
    wr_buf_d     = ~front_sel_q;
    rd_en        = 1'b0;
    rd_addr      = base_q + AW'(idx_q);

    case (state_q)
      S_INIT0, S_INIT1, S_FETCH: begin
        if (idx_q < IDX_END) begin
          // base only walks one stride per cycle when y jumped non-sequentially
          if (state_q == S_FETCH && base_line_q != fetch_line_q) begin
            if (base_line_q < fetch_line_q) begin
              base_d      = base_q + STRIDE;
              base_line_d = base_line_q + LW'(1);
            end else begin
              base_d      = base_q - STRIDE;
              base_line_d = base_line_q - LW'(1);
            end
          end else begin
            rd_en     = 1'b1;
            wr_pend_d = 1'b1;
            wr_buf_d  = (state_q == S_INIT0) ? front_sel_q : ~front_sel_q;
            idx_d     = idx_q + IW'(1);
          end
        end else begin
          // last read's data is written this cycle via the pending slot
          idx_d = '0;
          if (state_q == S_INIT0) begin
            state_d      = S_INIT1;
            base_d       = STRIDE;
            base_line_d  = LW'(1);
            fetch_line_d = LW'(1);
          end else begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    // A line change swaps buffers and restarts any fetch in flight.
    if (line_change) begin
      front_sel_d  = ~front_sel_q;
      state_d      = S_FETCH;
      idx_d        = '0;
      rd_en        = 1'b0;
      wr_pend_d    = 1'b0;
      fetch_line_d = next_line;
      base_d       = base_q;
      base_line_d  = base_line_q;
      if (next_line == '0) begin
        base_d      = '0;
        base_line_d = '0;
      end else if (next_line == base_line_q + LW'(1)) begin
        base_d      = base_q + STRIDE;
        base_line_d = next_line;
      end
    end
  end

  always_comb begin
    lb0_d = lb0_q;
    lb1_d = lb1_q;
    if (wr_pend_q) begin
      if (wr_buf_q) lb1_d[wr_idx_q[XW-1:0]] = ram_rdata;
      else          lb0_d[wr_idx_q[XW-1:0]] = ram_rdata;
    end
  end

  always_ff @(posedge clock25) begin
    if (!resetn) begin
      wr_addr_q    <= '0;
      state_q      <= S_INIT0;
      ready_q      <= 1'b0;
      y_prev_q     <= '0;
      front_sel_q  <= 1'b0;
      idx_q        <= '0;
      base_q       <= '0;
      base_line_q  <= '0;
      fetch_line_q <= '0;
      wr_pend_q    <= 1'b0;
      wr_idx_q     <= '0;
      wr_buf_q     <= 1'b0;
      lb0_q        <= '{default: '0};
      lb1_q        <= '{default: '0};
    end else begin
      wr_addr_q    <= wr_addr_d;
      state_q      <= state_d;
      ready_q      <= ready_d;
      y_prev_q     <= y_prev_d;
      front_sel_q  <= front_sel_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      base_line_q  <= base_line_d;
      fetch_line_q <= fetch_line_d;
      wr_pend_q    <= wr_pend_d;
      wr_idx_q     <= wr_idx_d;
      wr_buf_q     <= wr_buf_d;
      lb0_q        <= lb0_d;
      lb1_q        <= lb1_d;
    end
  end

  assign x_idx = (x < 12'(WIDTH)) ? x[XW-1:0] : '0;
  assign shade = front_sel_q ? lb1_q[x_idx] : lb0_q[x_idx];

  always_comb begin
    rgb = '0;
    if (ready_q && x < 12'(WIDTH)) begin
      if (!lcd_en) begin
        rgb = PAL0;
      end else begin
        case (shade)
          2'd0:    rgb = PAL0;
          2'd1:    rgb = PAL1;
          2'd2:    rgb = PAL2;
          default: rgb = PAL3;
        endcase
      end
    end
  end

  assign {r, g, b} = rgb;
  assign ready     = ready_q;

endmodule

// File: tb/tb_gb_framebuffer.sv
module tb_gb_framebuffer;

  logic        clock25 = 1'b0;
  logic        resetn = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_sof = 1'b0;
  logic [1:0]  pix_shade = 2'd0;
  logic        lcd_en = 1'b1;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic [7:0]  r, g, b;
  logic        ready;

  int checks = 0;
  int failures = 0;

  logic [23:0] pal [4] = '{24'hE0F8D0, 24'h88C070, 24'h346856, 24'h081820};

  gb_framebuffer dut (
    .clock25  (clock25),
    .resetn   (resetn),
    .pix_valid(pix_valid),
    .pix_sof  (pix_sof),
    .pix_shade(pix_shade),
    .lcd_en   (lcd_en),
    .x        (x),
    .y        (y),
    .r        (r),
    .g        (g),
    .b        (b),
    .ready    (ready)
  );

  always #5 clock25 = ~clock25;

  task automatic tick();
    @(posedge clock25);
    #1;
  endtask

  // mode 0: shade = addr mod 4, mode 1: shade = line mod 4
  task automatic write_frame(input int mode);
    for (int a = 0; a < 160 * 144; a++) begin
      pix_valid = 1'b1;
      pix_sof   = (a == 0);
      pix_shade = (mode == 0) ? 2'(a % 4) : 2'((a / 160) % 4);
      tick();
    end
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 400) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    x = 12'd0;
    y = 12'd0;
    tick();
    tick();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0", ready);
    end
    checks++;
    if ({r, g, b} !== 24'h0) begin
      failures++;
      $display("FAIL reset_rgb got=%h exp=000000", {r, g, b});
    end
    resetn = 1'b1;
  endtask

  task automatic test_frame_load();
    int n;
    write_frame(0);
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    wait_ready(n);
    checks++;
    if (!ready || n < 322 || n > 326) begin
      failures++;
      $display("FAIL ready_latency got=%0d cycles ready=%b exp=322..326", n, ready);
    end
    for (int i = 0; i < 160; i++) begin
      x = 12'(i);
      #1;
      checks++;
      if ({r, g, b} !== pal[i % 4]) begin
        failures++;
        $display("FAIL load_x%0d got=%h exp=%h", i, {r, g, b}, pal[i % 4]);
      end
    end
  endtask

  task automatic test_lcd_off();
    lcd_en = 1'b0;
    for (int i = 0; i < 160; i++) begin
      x = 12'(i);
      #1;
      checks++;
      if ({r, g, b} !== 24'hE0F8D0) begin
        failures++;
        $display("FAIL lcd_off_x%0d got=%h exp=e0f8d0", i, {r, g, b});
      end
    end
    lcd_en = 1'b1;
    x = 12'd160;
    #1;
    checks++;
    if ({r, g, b} !== 24'h0) begin
      failures++;
      $display("FAIL x160 got=%h exp=000000", {r, g, b});
    end
    x = 12'd4095;
    #1;
    checks++;
    if ({r, g, b} !== 24'h0) begin
      failures++;
      $display("FAIL x4095 got=%h exp=000000", {r, g, b});
    end
    x = 12'd0;
  endtask

  task automatic test_midstream_sof();
    logic [1:0] exp_sh [5] = '{2'd3, 2'd2, 2'd2, 2'd3, 2'd0};
    for (int a = 0; a < 5000; a++) begin
      pix_valid = 1'b1;
      pix_shade = 2'(a % 4);
      tick();
    end
    pix_sof   = 1'b1;
    pix_shade = 2'd3;
    tick();
    pix_sof   = 1'b0;
    pix_shade = 2'd2;
    tick();
    pix_valid = 1'b0;
    y = 12'd143;
    repeat (180) tick();
    y = 12'd0;
    repeat (180) tick();
    for (int i = 0; i < 5; i++) begin
      x = 12'(i);
      #1;
      checks++;
      if ({r, g, b} !== pal[exp_sh[i]]) begin
        failures++;
        $display("FAIL sof_x%0d got=%h exp=%h", i, {r, g, b}, pal[exp_sh[i]]);
      end
    end
  endtask

  task automatic test_line_walk();
    int ly;
    int xs [3] = '{0, 79, 159};
    write_frame(1);
    y = 12'd143;
    repeat (180) tick();
    y = 12'd0;
    repeat (180) tick();
    for (int s = 1; s <= 144; s++) begin
      ly = s % 144;
      y  = 12'(ly);
      repeat (180) tick();
      for (int k = 0; k < 3; k++) begin
        x = 12'(xs[k]);
        #1;
        checks++;
        if ({r, g, b} !== pal[ly % 4]) begin
          failures++;
          $display("FAIL walk_y%0d_x%0d got=%h exp=%h", ly, xs[k], {r, g, b}, pal[ly % 4]);
        end
      end
    end
  endtask

  task automatic test_abort();
    y = 12'd5;
    repeat (50) tick();
    y = 12'd6;
    repeat (170) tick();
    y = 12'd7;
    tick();
    for (int i = 0; i < 160; i++) begin
      x = 12'(i);
      #1;
      checks++;
      if ({r, g, b} !== pal[3]) begin
        failures++;
        $display("FAIL abort_x%0d got=%h exp=%h", i, {r, g, b}, pal[3]);
      end
    end
  endtask

  task automatic test_reset_midfetch();
    int n;
    y = 12'd8;
    repeat (20) tick();
    x = 12'd10;
    resetn = 1'b0;
    y = 12'd0;
    tick();
    checks++;
    if (ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_ready got=%b exp=0", ready);
    end
    checks++;
    if ({r, g, b} !== 24'h0) begin
      failures++;
      $display("FAIL midreset_rgb got=%h exp=000000", {r, g, b});
    end
    resetn = 1'b1;
    wait_ready(n);
    checks++;
    if (!ready || n < 322 || n > 326) begin
      failures++;
      $display("FAIL reinit_latency got=%0d cycles ready=%b exp=322..326", n, ready);
    end
    y = 12'd1;
    repeat (5) tick();
    for (int i = 0; i < 160; i += 50) begin
      x = 12'(i);
      #1;
      checks++;
      if ({r, g, b} !== pal[1]) begin
        failures++;
        $display("FAIL retained_x%0d got=%h exp=%h", i, {r, g, b}, pal[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_frame_load();
    test_lcd_off();
    test_midstream_sof();
    test_line_walk();
    test_abort();
    test_reset_midfetch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
